// File: rtl/commit_pkg.sv
// Commit classes shared by the commit ring and its consumers.
package commit_pkg;

    localparam int unsigned TypeW = 3;

    typedef enum logic [TypeW-1:0] {
        CtNull  = 3'd0,
        CtGpr   = 3'd1,
        CtGprIn = 3'd2,
        CtFpr   = 3'd3,
        CtFprIn = 3'd4,
        CtSw    = 3'd5,
        CtB     = 3'd6,
        CtX     = 3'd7
    } commit_type_t;

    function automatic logic is_in(commit_type_t t);
        return (t == CtGprIn) || (t == CtFprIn);
    endfunction

    function automatic logic is_serial(commit_type_t t);
        return (t == CtSw) || (t == CtB);
    endfunction

endpackage

// File: rtl/prefix_count.sv
// Length of the leading-ones run of an accept vector, bit 0 first.
module prefix_count #(
    parameter int unsigned W    = 2,
    parameter int unsigned CntW = $clog2(W + 1)
) (
    input  logic [W-1:0]    vec_i,
    output logic [CntW-1:0] cnt_o
);

    logic run;

    always_comb begin
        cnt_o = '0;
        run   = 1'b1;
        for (int i = 0; i < int'(W); i++) begin
            run = run & vec_i[i];
            if (run) begin
                cnt_o = CntW'(i + 1);
            end
        end
    end

endmodule

// File: rtl/commit_ring_mw.sv
// Multi-issue, multi-commit in-order commit ring with mispredict flush.
module commit_ring_mw
    import commit_pkg::*;
#(
    parameter int unsigned DEPTH_W  = 4,
    parameter int unsigned ISSUE_W  = 2,
    parameter int unsigned COMMIT_W = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [ISSUE_W-1:0]          issue_valid,
    input  logic [ISSUE_W*TypeW-1:0]    issue_type,
    output logic [ISSUE_W-1:0]          issue_ready,
    output logic [ISSUE_W*DEPTH_W-1:0]  issue_tag,
    output logic [COMMIT_W-1:0]         commit_valid,
    output logic [COMMIT_W*TypeW-1:0]   commit_type,
    output logic [COMMIT_W*DEPTH_W-1:0] commit_tag,
    input  logic [COMMIT_W-1:0]         commit_ready,
    input  logic                        flush,
    input  logic [DEPTH_W-1:0]          flush_tag,
    output logic                        empty,
    output logic                        full,
    output logic [DEPTH_W:0]            count,
    output logic [DEPTH_W:0]            in_count
);

    localparam int unsigned Depth = 1 << DEPTH_W;
    localparam int unsigned IcW   = $clog2(ISSUE_W + 1);
    localparam int unsigned CcW   = $clog2(COMMIT_W + 1);

    typedef logic [DEPTH_W-1:0] ptr_t;
    typedef logic [DEPTH_W:0]   cnt_t;

    ptr_t         issue_ptr_q, issue_ptr_d;
    ptr_t         commit_ptr_q, commit_ptr_d;
    cnt_t         count_q, count_d;
    cnt_t         in_count_q, in_count_d;
    commit_type_t entry_q [Depth];
    commit_type_t entry_d [Depth];

    logic [ISSUE_W-1:0]  issue_acc;
    logic [COMMIT_W-1:0] commit_acc;
    logic [IcW-1:0]      n_issue;
    logic [CcW-1:0]      n_commit;
    ptr_t                flush_age;
    ptr_t                cidx;
    logic                serial_seen;

    assign flush_age = flush_tag - commit_ptr_q;

    // Readiness looks only at the registered count, so a full ring never
    // accepts an issue onto a slot that is committing in the same cycle.
    always_comb begin
        issue_ready = '0;
        issue_tag   = '0;
        issue_acc   = '0;
        for (int i = 0; i < int'(ISSUE_W); i++) begin
            issue_ready[i]                   = count_q <= cnt_t'(Depth - 32'(i) - 1);
            issue_tag[i*DEPTH_W +: DEPTH_W]  = issue_ptr_q + ptr_t'(i);
            issue_acc[i]                     = issue_valid[i] & issue_ready[i] & ~flush;
        end
    end

    // SW/B stop younger slots, so they only ever retire from slot 0. During a
    // flush nothing younger than flush_tag may retire.
    always_comb begin
        commit_valid = '0;
        commit_type  = '0;
        commit_tag   = '0;
        commit_acc   = '0;
        serial_seen  = 1'b0;
        cidx         = '0;
        for (int k = 0; k < int'(COMMIT_W); k++) begin
            cidx                               = commit_ptr_q + ptr_t'(k);
            commit_tag[k*DEPTH_W +: DEPTH_W]   = cidx;
            commit_type[k*TypeW +: TypeW]      = entry_q[cidx];
            commit_valid[k]                    = (count_q > cnt_t'(k)) && !serial_seen;
            serial_seen                        = serial_seen | is_serial(entry_q[cidx]);
            commit_acc[k] = commit_valid[k] & commit_ready[k]
                          & (~flush | (ptr_t'(k) <= flush_age));
        end
    end

    prefix_count #(
        .W    (ISSUE_W),
        .CntW (IcW)
    ) u_issue_cnt (
        .vec_i (issue_acc),
        .cnt_o (n_issue)
    );

    prefix_count #(
        .W    (COMMIT_W),
        .CntW (CcW)
    ) u_commit_cnt (
        .vec_i (commit_acc),
        .cnt_o (n_commit)
    );

    always_comb begin
        entry_d = entry_q;
        for (int e = 0; e < int'(Depth); e++) begin
            if (flush && ((ptr_t'(e) - commit_ptr_q) > flush_age)) begin
                entry_d[e] = CtNull;
            end
        end
        for (int k = 0; k < int'(COMMIT_W); k++) begin
            if (int'(n_commit) > k) begin
                entry_d[commit_ptr_q + ptr_t'(k)] = CtNull;
            end
        end
        for (int i = 0; i < int'(ISSUE_W); i++) begin
            if (int'(n_issue) > i) begin
                entry_d[issue_ptr_q + ptr_t'(i)] =
                    commit_type_t'(issue_type[i*TypeW +: TypeW]);
            end
        end

        in_count_d = '0;
        for (int e = 0; e < int'(Depth); e++) begin
            if (is_in(entry_d[e])) begin
                in_count_d = in_count_d + cnt_t'(1);
            end
        end

        commit_ptr_d = commit_ptr_q + ptr_t'(n_commit);
        if (flush) begin
            issue_ptr_d = flush_tag + ptr_t'(1);
            count_d     = cnt_t'(flush_age) + cnt_t'(1) - cnt_t'(n_commit);
        end else begin
            issue_ptr_d = issue_ptr_q + ptr_t'(n_issue);
            count_d     = count_q + cnt_t'(n_issue) - cnt_t'(n_commit);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            issue_ptr_q  <= '0;
            commit_ptr_q <= '0;
            count_q      <= '0;
            in_count_q   <= '0;
            for (int e = 0; e < int'(Depth); e++) begin
                entry_q[e] <= CtNull;
            end
        end else begin
            issue_ptr_q  <= issue_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            count_q      <= count_d;
            in_count_q   <= in_count_d;
            entry_q      <= entry_d;
        end
    end

    assign count    = count_q;
    assign in_count = in_count_q;
    assign empty    = (count_q == '0);
    assign full     = (count_q == cnt_t'(Depth));

endmodule

// File: tb/tb_commit_ring_mw.sv
// Scoreboard bench for commit_ring_mw: the ring is modelled as a program-order queue.
module tb_commit_ring_mw;
    import commit_pkg::*;

    localparam int DW    = 4;
    localparam int IW    = 2;
    localparam int CW    = 2;
    localparam int DEPTH = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [IW-1:0]     issue_valid = '0;
    logic [IW*3-1:0]   issue_type = '0;
    logic [IW-1:0]     issue_ready;
    logic [IW*DW-1:0]  issue_tag;
    logic [CW-1:0]     commit_valid;
    logic [CW*3-1:0]   commit_type;
    logic [CW*DW-1:0]  commit_tag;
    logic [CW-1:0]     commit_ready = '0;
    logic              flush = 1'b0;
    logic [DW-1:0]     flush_tag = '0;
    logic              empty, full;
    logic [DW:0]       count, in_count;

    always #5 clk = ~clk;

    commit_ring_mw #(
        .DEPTH_W  (DW),
        .ISSUE_W  (IW),
        .COMMIT_W (CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .issue_valid  (issue_valid),
        .issue_type   (issue_type),
        .issue_ready  (issue_ready),
        .issue_tag    (issue_tag),
        .commit_valid (commit_valid),
        .commit_type  (commit_type),
        .commit_tag   (commit_tag),
        .commit_ready (commit_ready),
        .flush        (flush),
        .flush_tag    (flush_tag),
        .empty        (empty),
        .full         (full),
        .count        (count),
        .in_count     (in_count)
    );

    typedef struct {
        logic [DW-1:0] tag;
        logic [2:0]    ty;
    } ent_t;

    ent_t          sb_q[$];      // occupied entries, oldest first
    logic [DW-1:0] next_tag = '0;
    int            checks = 0;
    int            errors = 0;
    bit            mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit is_in_ty(logic [2:0] t);
        return (t == CtGprIn) || (t == CtFprIn);
    endfunction

    function automatic bit is_ser_ty(logic [2:0] t);
        return (t == CtSw) || (t == CtB);
    endfunction

    // Monitor: compares registered outputs with the queue and retires commits.
    initial begin : monitor
        int            n, lim, nf;
        bit            ser;
        logic [CW-1:0] ecv;
        logic [DW-1:0] et;
        int            icnt;
        forever begin
            @(negedge clk);
            #1;
            if (mon_en) begin
                n    = sb_q.size();
                icnt = 0;
                foreach (sb_q[q]) if (is_in_ty(sb_q[q].ty)) icnt++;
                chk("count", 32'(count), n);
                chk("in_count", 32'(in_count), icnt);
                chk("empty", 32'(empty), 32'(n == 0));
                chk("full", 32'(full), 32'(n == DEPTH));
                for (int i = 0; i < IW; i++) begin
                    et = next_tag + DW'(i);
                    chk("issue_ready", 32'(issue_ready[i]), 32'(n <= DEPTH - (i + 1)));
                    chk("issue_tag", 32'(issue_tag[i*DW +: DW]), 32'(et));
                end
                ser = 1'b0;
                ecv = '0;
                for (int k = 0; k < CW; k++) begin
                    if (k < n) begin
                        ecv[k] = !ser;
                        ser    = ser | is_ser_ty(sb_q[k].ty);
                    end
                end
                chk("commit_valid", 32'(commit_valid), 32'(ecv));
                for (int k = 0; k < CW; k++) begin
                    if (ecv[k]) begin
                        chk("commit_type", 32'(commit_type[k*3 +: 3]), 32'(sb_q[k].ty));
                        chk("commit_tag", 32'(commit_tag[k*DW +: DW]), 32'(sb_q[k].tag));
                    end
                end
                if (!reset) begin
                    lim = CW;
                    if (flush) begin
                        foreach (sb_q[q]) if (sb_q[q].tag == flush_tag) lim = q + 1;
                    end
                    nf = 0;
                    for (int k = 0; k < CW; k++) begin
                        if (ecv[k] && commit_ready[k] && k < lim && nf == k) nf++;
                    end
                    repeat (nf) void'(sb_q.pop_front());
                end
            end
        end
    end

    // One cycle of stimulus; the queue is updated after the monitor's pops.
    task automatic step(input bit rst, input logic [IW-1:0] iv, input logic [2:0] t0,
                        input logic [2:0] t1, input logic [CW-1:0] cr, input bit fl,
                        input logic [DW-1:0] ft);
        int n, nacc, j;
        @(negedge clk);
        reset        = rst;
        issue_valid  = iv;
        issue_type   = {t1, t0};
        commit_ready = cr;
        flush        = fl;
        flush_tag    = ft;
        n    = sb_q.size();
        nacc = 0;
        for (int i = 0; i < IW; i++) begin
            if (!rst && !fl && iv[i] && n <= DEPTH - (i + 1) && nacc == i) nacc++;
        end
        #2;
        if (rst) begin
            sb_q.delete();
            next_tag = '0;
        end else begin
            if (fl) begin
                j = -1;
                foreach (sb_q[q]) if (sb_q[q].tag == ft) j = q;
                while (sb_q.size() > j + 1) void'(sb_q.pop_back());
                next_tag = ft + DW'(1);
            end
            for (int i = 0; i < nacc; i++) begin
                sb_q.push_back('{tag: next_tag, ty: (i == 0) ? t0 : t1});
                next_tag = next_tag + DW'(1);
            end
        end
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int n = 0; n < 40 && sb_q.size() > 0; n++) begin
            step(0, '0, CtNull, CtNull, 2'b11, 0, '0);
        end
        after_edge();
        chk("drain_empty", 32'(empty), 1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end

    initial begin : stim
        bit            r_rst, r_fl;
        logic [IW-1:0] r_iv;
        logic [CW-1:0] r_cr;
        logic [DW-1:0] r_ft;

        step(1, '0, CtNull, CtNull, '0, 0, '0);
        step(1, '0, CtNull, CtNull, '0, 0, '0);
        mon_en = 1'b1;
        after_edge();
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_commit_valid", 32'(commit_valid), 0);
        chk("rst_issue_ready", 32'(issue_ready), 32'h3);

        // Dual issue, then read both slots back.
        step(0, 2'b11, CtGpr, CtFprIn, 2'b00, 0, '0);
        after_edge();
        chk("dual_count", 32'(count), 2);
        chk("dual_in_count", 32'(in_count), 1);
        chk("dual_commit_valid", 32'(commit_valid), 32'h3);
        chk("dual_commit_type", 32'(commit_type), 32'h21);
        chk("dual_commit_tag", 32'(commit_tag), 32'h10);
        drain();

        // Fill all 16 slots, try a 17th, then free two.
        for (int i = 0; i < DEPTH; i++) step(0, 2'b01, CtGpr, CtNull, 2'b00, 0, '0);
        after_edge();
        chk("fill_full", 32'(full), 1);
        chk("fill_count", 32'(count), 16);
        chk("fill_issue_ready", 32'(issue_ready), 0);
        step(0, 2'b01, CtGpr, CtNull, 2'b00, 0, '0);
        after_edge();
        chk("overfill_count", 32'(count), 16);
        step(0, 2'b00, CtNull, CtNull, 2'b11, 0, '0);
        after_edge();
        chk("freed_issue_ready", 32'(issue_ready), 32'h3);
        drain();

        // Serialising store at the head.
        step(0, 2'b11, CtSw, CtGpr, 2'b11, 0, '0);
        after_edge();
        chk("sw_commit_valid", 32'(commit_valid), 32'h1);
        step(0, 2'b00, CtNull, CtNull, 2'b11, 0, '0);
        after_edge();
        chk("sw_alone_count", 32'(count), 1);
        chk("sw_next_type", 32'(commit_type[2:0]), 32'(CtGpr));
        drain();

        // Walk pointers to 14, then issue across the wrap.
        for (int i = 0; i < 5; i++) step(0, 2'b11, CtGpr, CtGpr, 2'b11, 0, '0);
        drain();
        step(0, 2'b11, CtGpr, CtFprIn, 2'b00, 0, '0);
        step(0, 2'b11, CtFpr, CtGprIn, 2'b00, 0, '0);
        after_edge();
        chk("wrap_count", 32'(count), 4);
        chk("wrap_commit_tag", 32'(commit_tag), 32'hFE);
        chk("wrap_in_count", 32'(in_count), 2);
        drain();

        // Entries at tags 3..8, flush back to the branch at tag 5.
        step(0, 2'b01, CtGpr, CtNull, 2'b00, 0, '0);
        step(0, 2'b00, CtNull, CtNull, 2'b01, 0, '0);
        step(0, 2'b11, CtGpr, CtFpr, 2'b00, 0, '0);
        step(0, 2'b11, CtB, CtGpr, 2'b00, 0, '0);
        step(0, 2'b11, CtGprIn, CtFpr, 2'b00, 0, '0);
        step(0, 2'b11, CtGpr, CtGpr, 2'b00, 1, 4'd5);
        after_edge();
        chk("flush_count", 32'(count), 3);
        chk("flush_in_count", 32'(in_count), 0);
        chk("flush_issue_tag0", 32'(issue_tag[DW-1:0]), 6);
        drain();

        // Reset wins over issue and flush while full.
        for (int i = 0; i < DEPTH / 2; i++) step(0, 2'b11, CtGpr, CtGprIn, 2'b00, 0, '0);
        after_edge();
        chk("prerst_full", 32'(full), 1);
        step(1, 2'b11, CtGpr, CtGpr, 2'b11, 1, next_tag - DW'(1));
        after_edge();
        chk("midrst_empty", 32'(empty), 1);
        chk("midrst_count", 32'(count), 0);
        chk("midrst_commit_valid", 32'(commit_valid), 0);

        // Random traffic against the queue model.
        for (int c = 0; c < 600; c++) begin
            r_rst = ($urandom_range(0, 199) == 0);
            r_iv  = IW'($urandom);
            r_cr  = ($urandom_range(0, 3) != 0) ? CW'($urandom | 1) : CW'($urandom);
            r_fl  = (sb_q.size() > 0) && ($urandom_range(0, 11) == 0);
            r_ft  = '0;
            if (r_fl) r_ft = sb_q[$urandom_range(0, sb_q.size() - 1)].tag;
            step(r_rst, r_iv, 3'($urandom_range(1, 6)), 3'($urandom_range(1, 6)),
                 r_cr, r_fl, r_ft);
        end
        step(0, '0, CtNull, CtNull, '0, 0, '0);
        step(0, '0, CtNull, CtNull, '0, 0, '0);
        after_edge();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/commit_ring_mw.md
Name: commit_ring_mw

Overview:
- Multi-wide, parametrised in-order commit ring. Records the commit class of every issued instruction in program order and retires up to COMMIT_W entries per cycle.
- Sits between the issue stage (up to ISSUE_W allocations/cycle) and the GPR/FPR/store/branch commit logic.
- Adds over the single-wide ring: multi-issue, multi-commit, use of all 2**DEPTH_W slots, branch-mispredict flush of younger entries, and full/count outputs.

Parameters:
- DEPTH_W, 4, log2 of ring depth (16 entries).
- ISSUE_W, 2, allocation slots per cycle (1..4).
- COMMIT_W, 2, commit slots per cycle (1..4).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- issue_valid  in  ISSUE_W  per-slot allocation request; slot 0 is oldest.
- issue_type  in  ISSUE_W x commit_type_t  class of each issuing instruction.
- issue_ready  out  ISSUE_W  slot i ready iff registered count <= 2**DEPTH_W-(i+1).
- issue_tag  out  ISSUE_W x DEPTH_W  ring index assigned to slot i (issue_ptr+i).
- commit_valid  out  COMMIT_W  slot k holds a committable entry.
- commit_type  out  COMMIT_W x commit_type_t  class at commit_ptr+k.
- commit_tag  out  COMMIT_W x DEPTH_W  ring index of slot k.
- commit_ready  in  COMMIT_W  consumer accepts slot k.
- flush  in  1  discard all entries younger than flush_tag.
- flush_tag  in  DEPTH_W  index of last surviving entry; must be occupied.
- empty  out  1  count==0.
- full  out  1  count==2**DEPTH_W.
- count  out  DEPTH_W+1  occupied entries, registered.
- in_count  out  DEPTH_W+1  occupied entries of class GPR_IN or FPR_IN, registered.

Behaviour:
- State:
  - issue_ptr and commit_ptr, DEPTH_W bits each, wrapping mod 2**DEPTH_W.
  - count register. Full and empty are distinguished by count, not pointer equality, so all 2**DEPTH_W slots are usable.
  - entry[] array of commit_type_t.
- Reset:
  - Pointers = 0, count = 0, in_count = 0, all entries = NULL.
  - Resulting outputs: empty = 1, full = 0, commit_valid = 0, issue_ready = all 1.
  - Reset overrides issue, commit and flush in the same cycle.
- Issue:
  - Slot i is accepted iff issue_valid[i] && issue_ready[i] && slot i-1 was accepted. Acceptance is prefix-contiguous, so a gap stops all later slots.
  - Accepted slots write entry[issue_ptr+i] <= issue_type[i].
  - issue_ptr advances by the number accepted.
  - issue_ready uses only the registered count; same-cycle commits do not free space.
- Commit:
  - commit_valid[k] = (count > k) && no slot j<k has type SW or B. SW and B entries therefore serialise and commit only from slot 0.
  - Slot k commits iff commit_valid[k] && commit_ready[k] && slot k-1 committed (prefix).
  - Committed entries become NULL; commit_ptr advances by the number committed.
  - An entry issued in cycle t is visible at a commit slot no earlier than cycle t+1.
- Count update: count_next = count + n_issue - n_commit - n_flushed.
- Flush:
  - Sets issue_ptr_next = flush_tag+1 and NULLs every entry strictly younger than flush_tag (commit_ptr-relative ordering).
  - Issue acceptance is suppressed in the flush cycle.
  - Commit proceeds in the same cycle. If flush_tag itself commits that cycle, it is still removed as committed, not as flushed.
  - A flush with flush_tag == youngest entry is a no-op apart from blocking issue.
- in_count: registered; equals the popcount of GPR_IN/FPR_IN over entry_next.
- Illegal-value entries (X) are never written.
- Simultaneous issue and commit on the same index is impossible, because issue_ready excludes full.
- Pointer arithmetic: DEPTH_W-bit wrap. Age comparison uses (idx - commit_ptr) mod 2**DEPTH_W.

Decomposition:
- Package commit_pkg:
  - commit_type_t 3-bit enum: NULL, GPR, GPR_IN, FPR, FPR_IN, SW, B, X.
  - Helpers is_in(t) and is_serial(t) (SW or B).
- Sub-module prefix_count #(W): given a W-bit accept vector, returns the length of its leading-ones prefix. Instantiated twice, for issue and for commit.

Test Plan:
- Reset, then issue types {GPR, FPR_IN} on 2 slots in one cycle → next cycle count=2, in_count=1, commit_valid=2'b11, commit_type={GPR, FPR_IN}, commit_tag={0,1}.
- Fill with 16 single GPR issues, commit_ready=0 → full=1, count=16, issue_ready=2'b00; a 17th issue is not accepted. Then commit 2 → the following cycle issue_ready=2'b11.
- Issue {SW, GPR} with commit_ready=2'b11 → slot 1 invalid while SW is at the head; SW commits alone, GPR commits the next cycle.
- Pointers at 14, issue 4 entries across wrap → tags 14, 15, 0, 1; commits retire them in that order; empty=1 afterwards.
- Entries at tags 3..8 (tag 5 is B, tag 7 is GPR_IN), flush with flush_tag=5 plus a same-cycle issue → issue rejected; next cycle count=3, in_count=0, issue_tag[0]=6.
- Reset asserted while full with flush=1 and issue_valid=11 → next cycle empty=1, count=0, all commit_valid=0.
